// File: rtl/median_window_feeder.sv
// Raster-to-3x3 window feeder for the median cell's serial DI/DSI load port.
// Optional MEDFEED_SOF_EN adds PIX_SOF to realign the raster counters to (0,0).
module median_window_feeder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] PIX_I,
    input  logic             PIX_VALID,
`ifdef MEDFEED_SOF_EN
    input  logic             PIX_SOF,
`endif
    output logic             PIX_READY,
    output logic [WIDTH-1:0] DO,
    output logic             DSI,
    input  logic             MED_DONE
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned NWIN = 9;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t           r_state;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [3:0]       r_k;
    logic [WIDTH-1:0] r_win [NWIN];
    logic [WIDTH-1:0] r_l1  [IMG_W];
    logic [WIDTH-1:0] r_l2  [IMG_W];

    logic             w_accept;
    logic [XW-1:0]    w_x;
    logic [YW-1:0]    w_y;
    logic             w_last_x;
    logic             w_last_y;
    logic             w_complete;

    assign PIX_READY = (r_state == ST_ACCEPT);
    assign w_accept  = PIX_VALID && (r_state == ST_ACCEPT);

    // Position of the pixel on the input this cycle
`ifdef MEDFEED_SOF_EN
    assign w_x = PIX_SOF ? '0 : r_x;
    assign w_y = PIX_SOF ? '0 : r_y;
`else
    assign w_x = r_x;
    assign w_y = r_y;
`endif

    assign w_last_x   = (w_x == XW'(IMG_W - 1));
    assign w_last_y   = (w_y == YW'(IMG_H - 1));
    assign w_complete = (w_x >= XW'(2)) && (w_y >= YW'(2));

    // Line buffers need no reset: a column is always rewritten before it feeds a window
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_l2[w_x] <= r_l1[w_x];
            r_l1[w_x] <= PIX_I;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_ACCEPT;
            r_x     <= '0;
            r_y     <= '0;
            r_k     <= '0;
            DO      <= '0;
            DSI     <= 1'b0;
            for (int i = 0; i < int'(NWIN); i++) begin
                r_win[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    DSI <= 1'b0;
                    if (w_accept) begin
                        if (w_last_x) begin
                            r_x <= '0;
                            r_y <= w_last_y ? '0 : w_y + YW'(1);
                        end else begin
                            r_x <= w_x + XW'(1);
                            r_y <= w_y;
                        end
                        // Window stored row-major; column 2 is the newest
                        for (int r = 0; r < 3; r++) begin
                            r_win[3*r]   <= r_win[3*r+1];
                            r_win[3*r+1] <= r_win[3*r+2];
                        end
                        r_win[2] <= r_l2[w_x];
                        r_win[5] <= r_l1[w_x];
                        r_win[8] <= PIX_I;
                        if (w_complete) begin
                            r_state <= ST_SEND;
                            r_k     <= '0;
                        end
                    end
                end
                ST_SEND: begin
                    DSI <= 1'b1;
                    DO  <= r_win[r_k];
                    if (r_k == 4'd8) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                ST_WAIT: begin
                    DSI <= 1'b0;
                    if (MED_DONE) begin
                        r_state <= ST_ACCEPT;
                    end
                end
                default: begin
                    r_state <= ST_ACCEPT;
                    DSI     <= 1'b0;
                end
            endcase
        end
    end

endmodule
